// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

  localparam logic LIF_RST_ZERO = 1'b0;
  localparam logic LIF_RST_SUB  = 1'b1;

  // Unsigned add of two values already confined to `width` bits, clamped to 2^width-1.
  // Works for any width up to 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_array_if.sv
// Step/current/threshold inputs and spike/state outputs of the neuron array.
interface lif_array_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  logic                       step;
  logic [N_NEURONS*WIDTH-1:0] current;
  logic                       thr_wr;
  logic [WIDTH-1:0]           thr_data;
  logic                       reset_mode;
  logic [N_NEURONS-1:0]       spike;
  logic [N_NEURONS*WIDTH-1:0] state;
  logic                       spike_any;

  modport master (
    output step, current, thr_wr, thr_data, reset_mode,
    input  spike, state, spike_any
  );

  modport slave (
    input  step, current, thr_wr, thr_data, reset_mode,
    output spike, state, spike_any
  );
endinterface

// File: rtl/lif_neuron.sv
// One LIF channel: leak, saturating integrate, threshold compare, post-spike reset, refractory.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int LEAK_SHIFT   = 1,
  parameter int REFRAC_STEPS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic [WIDTH-1:0] current,
  input  logic [WIDTH-1:0] threshold,
  input  logic             reset_mode,
  output logic [WIDTH-1:0] state,
  output logic             spike,
  output logic             fire
);

  localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  logic [WIDTH-1:0] state_q;
  logic [RW-1:0]    refrac_q;
  logic             spike_q;
  logic [WIDTH-1:0] sum;
  logic             refractory;

  always_comb begin
    refractory = (refrac_q != '0);
    sum        = WIDTH'(sat_add(32'(current), 32'(state_q >> LEAK_SHIFT), WIDTH));
    // fire is exported unregistered so the top can register spike_any in the same edge
    fire       = step && !refractory && (sum >= threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      refrac_q <= '0;
      spike_q  <= 1'b0;
    end else begin
      spike_q <= fire;
      if (step) begin
        if (refractory) begin
          refrac_q <= refrac_q - RW'(1);
        end else if (fire) begin
          refrac_q <= RW'(REFRAC_STEPS);
          state_q  <= (reset_mode == LIF_RST_SUB) ? (sum - threshold) : '0;
        end else begin
          state_q <= sum;
        end
      end
    end
  end

  assign state = state_q;
  assign spike = spike_q;

endmodule

// File: rtl/lif_array.sv
// Array of LIF channels sharing a runtime-loadable threshold; also registers spike_any.
module lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS         = 4,
  parameter int WIDTH             = 8,
  parameter int LEAK_SHIFT        = 1,
  parameter int REFRAC_STEPS      = 2,
  parameter int DEFAULT_THRESHOLD = 127
) (
  input logic        clk,
  input logic        rst_n,
  lif_array_if.slave bus
);

  logic [WIDTH-1:0]           threshold_q;
  logic                       spike_any_q;
  logic [N_NEURONS-1:0]       fire_v;
  logic [N_NEURONS-1:0]       spike_v;
  logic [N_NEURONS*WIDTH-1:0] state_v;

  // A write coinciding with a step lands at the same edge, so that step still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold_q <= WIDTH'(DEFAULT_THRESHOLD);
      spike_any_q <= 1'b0;
    end else begin
      spike_any_q <= |fire_v;
      if (bus.thr_wr) threshold_q <= bus.thr_data;
    end
  end

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_ch
    lif_neuron #(
      .WIDTH       (WIDTH),
      .LEAK_SHIFT  (LEAK_SHIFT),
      .REFRAC_STEPS(REFRAC_STEPS)
    ) u_neuron (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (bus.step),
      .current    (bus.current[i*WIDTH +: WIDTH]),
      .threshold  (threshold_q),
      .reset_mode (bus.reset_mode),
      .state      (state_v[i*WIDTH +: WIDTH]),
      .spike      (spike_v[i]),
      .fire       (fire_v[i])
    );
  end

  assign bus.spike     = spike_v;
  assign bus.state     = state_v;
  assign bus.spike_any = spike_any_q;

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: default-parameter instance plus a no-refractory instance.
module tb_lif_array;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         step = 1'b0;
  logic [N*W-1:0] current = '0;
  logic         thr_wr = 1'b0;
  logic [W-1:0] thr_data = '0;
  logic         reset_mode = 1'b0;
  bit           done = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lif_array_if #(.N_NEURONS(N), .WIDTH(W)) bus_a ();
  lif_array_if #(.N_NEURONS(N), .WIDTH(W)) bus_b ();

  assign bus_a.step = step;  assign bus_a.current = current;  assign bus_a.thr_wr = thr_wr;
  assign bus_a.thr_data = thr_data;  assign bus_a.reset_mode = reset_mode;
  assign bus_b.step = step;  assign bus_b.current = current;  assign bus_b.thr_wr = thr_wr;
  assign bus_b.thr_data = thr_data;  assign bus_b.reset_mode = reset_mode;

  lif_array #(.N_NEURONS(N), .WIDTH(W), .LEAK_SHIFT(1), .REFRAC_STEPS(2),
              .DEFAULT_THRESHOLD(127)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  lif_array #(.N_NEURONS(N), .WIDTH(W), .LEAK_SHIFT(1), .REFRAC_STEPS(0),
              .DEFAULT_THRESHOLD(127)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Behavioural model: index 0 mirrors dut (2 refractory steps), index 1 mirrors dut0 (none).
  int m_st[2][N];
  int m_rf[2][N];
  bit m_sp[2][N];
  int m_thr;

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        m_st[d][i] = 0; m_rf[d][i] = 0; m_sp[d][i] = 0;
      end
    m_thr = 127;
  endtask

  task automatic model_step();
    int s;
    if (!rst_n) return;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        m_sp[d][i] = 0;
        if (step) begin
          if (m_rf[d][i] > 0) m_rf[d][i] = m_rf[d][i] - 1;
          else begin
            s = int'(current[i*W +: W]) + m_st[d][i] / 2;
            if (s > 255) s = 255;
            if (s >= m_thr) begin
              m_sp[d][i] = 1;
              m_rf[d][i] = (d == 0) ? 2 : 0;
              m_st[d][i] = reset_mode ? s - m_thr : 0;
            end else m_st[d][i] = s;
          end
        end
      end
    if (thr_wr) m_thr = int'(thr_data);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
    current = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endtask

  function automatic logic [7:0] st_a(input int i);
    return bus_a.state[i*W +: W];
  endfunction

  // Every cycle, away from the rising edge, compare both instances to the model.
  initial begin
    logic any0, any1;
    forever begin
      @(negedge clk);
      if (!done) begin
        any0 = 0; any1 = 0;
        for (int i = 0; i < N; i++) begin
          chk($sformatf("a_state%0d", i), 32'(bus_a.state[i*W +: W]), m_st[0][i]);
          chk($sformatf("a_spike%0d", i), 32'(bus_a.spike[i]), 32'(m_sp[0][i]));
          chk($sformatf("b_state%0d", i), 32'(bus_b.state[i*W +: W]), m_st[1][i]);
          chk($sformatf("b_spike%0d", i), 32'(bus_b.spike[i]), 32'(m_sp[1][i]));
          any0 |= m_sp[0][i]; any1 |= m_sp[1][i];
        end
        chk("a_spike_any", 32'(bus_a.spike_any), 32'(any0));
        chk("b_spike_any", 32'(bus_b.spike_any), 32'(any1));
      end
    end
  end

  initial begin
    int exp_st[10] = '{64, 96, 112, 120, 124, 126, 0, 0, 0, 64};
    bit exp_sp[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    model_reset();

    // Reset held with random activity on the inputs
    repeat (3) begin
      current = $urandom; step = 1'($urandom_range(0, 1));
      thr_wr = 1'b1; thr_data = 8'($urandom); reset_mode = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_state_a", 32'(bus_a.state), 0);
    chk("rst_spike_a", 32'(bus_a.spike), 0);
    chk("rst_any_a", 32'(bus_a.spike_any), 0);
    step = 0; thr_wr = 0; current = '0; reset_mode = 0;
    rst_n = 1'b1;

    set_cur(10, 0, 0, 0); step = 1; tick();
    chk("first_step_state0", 32'(st_a(0)), 10);
    step = 0; pulse_reset();

    // Integration and fire, mode 0, then refractory
    set_cur(64, 0, 0, 0); step = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("integ_state0_step%0d", k + 1), 32'(st_a(0)), exp_st[k]);
      chk($sformatf("integ_spike0_step%0d", k + 1), 32'(bus_a.spike[0]), 32'(exp_sp[k]));
    end
    step = 0; pulse_reset();

    // Saturation, mode 1
    reset_mode = 1; set_cur(0, 255, 0, 0); step = 1; tick();
    chk("sat_state1", 32'(st_a(1)), 128);
    chk("sat_spike", 32'(bus_a.spike), 32'h2);
    chk("sat_any", 32'(bus_a.spike_any), 1);
    chk("sat_state0", 32'(st_a(0)), 0);
    step = 0; pulse_reset();

    // Threshold write coinciding with a step
    reset_mode = 0; set_cur(60, 0, 0, 0); step = 1; thr_wr = 1; thr_data = 50; tick();
    chk("thr_old_spike0", 32'(bus_a.spike[0]), 0);
    chk("thr_old_state0", 32'(st_a(0)), 60);
    thr_wr = 0; tick();
    chk("thr_new_spike0", 32'(bus_a.spike[0]), 1);
    chk("thr_new_state0", 32'(st_a(0)), 0);

    // Idle cycles, then refractory consumed only by steps
    step = 0; set_cur(77, 77, 77, 77);
    repeat (5) tick();
    chk("idle_state0", 32'(st_a(0)), 0);
    chk("idle_spike", 32'(bus_a.spike), 0);
    step = 1; tick();
    chk("refr1_state0", 32'(st_a(0)), 0);
    chk("refr1_spike0", 32'(bus_a.spike[0]), 0);
    tick();
    chk("refr2_spike0", 32'(bus_a.spike[0]), 0);
    tick();
    chk("refr_done_spike0", 32'(bus_a.spike[0]), 1);

    // Back-to-back firing without refractory
    set_cur(255, 255, 255, 255);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("b2b_spike_c%0d", k), 32'(bus_b.spike), 32'hF);
      chk($sformatf("b2b_any_c%0d", k), 32'(bus_b.spike_any), 1);
    end
    step = 0; pulse_reset();

    // Async reset while refractory, threshold previously rewritten
    reset_mode = 1; set_cur(255, 0, 0, 0); step = 1; thr_wr = 1; thr_data = 50; tick();
    chk("pre_rst_state0", 32'(st_a(0)), 128);
    chk("pre_rst_spike0", 32'(bus_a.spike[0]), 1);
    step = 0; thr_wr = 0; reset_mode = 0;
    #1 rst_n = 1'b0; model_reset();
    #1;
    chk("mid_rst_state0", 32'(st_a(0)), 0);
    chk("mid_rst_spike", 32'(bus_a.spike), 0);
    chk("mid_rst_any", 32'(bus_a.spike_any), 0);
    rst_n = 1'b1;
    set_cur(60, 0, 0, 0); step = 1; tick();
    chk("post_rst_state0", 32'(st_a(0)), 60);
    tick();
    chk("post_rst_thr_state0", 32'(st_a(0)), 90);
    chk("post_rst_thr_spike0", 32'(bus_a.spike[0]), 0);
    step = 0; tick();

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lif_array.md
# lif_array

Parametrised array of leaky integrate-and-fire neurons; the successor to the single 8-bit LIF cell. Each of `N_NEURONS` independent channels integrates its input current once per `step` strobe with a configurable leak, and fires against a shared runtime-loadable threshold. Each channel has a selectable post-spike reset (to zero or by subtraction) and an optional refractory period. It sits between the input-current front end and the winner-take-all/spike-encoding logic.

## Interface
Parameters:
- `N_NEURONS`, 4, number of channels (≥1)
- `WIDTH`, 8, membrane/current/threshold width in bits (≥2)
- `LEAK_SHIFT`, 1, leak as right shift of state per step (0..WIDTH-1; 1 ≙ beta 0.5)
- `REFRAC_STEPS`, 2, steps a channel ignores input after firing (0 = none)
- `DEFAULT_THRESHOLD`, 127, threshold value after reset

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `step` in 1: advance all channels one timestep this cycle
- `current` in N_NEURONS*WIDTH: unsigned input; channel i at `[i*WIDTH +: WIDTH]`
- `thr_wr` in 1: load `thr_data` into shared threshold
- `thr_data` in WIDTH: threshold value
- `reset_mode` in 1: 0 = reset-to-zero, 1 = reset-by-subtraction
- `spike` out N_NEURONS: registered one-cycle fire pulses
- `state` out N_NEURONS*WIDTH: registered membrane potentials, same packing as `current`
- `spike_any` out 1: registered OR of `spike`

## Operation
- Per channel, registers: `state` (WIDTH), `refrac` (max(1, clog2(REFRAC_STEPS+1)) bits), `spike` (1). Shared register: `threshold` (WIDTH).
- On a cycle with `step`=1, each channel i independently:
  - If `refrac != 0`: `refrac` decrements, `state` is held, `spike` ← 0, input is ignored.
  - Otherwise: `sum = current_i + (state_i >> LEAK_SHIFT)`, computed in WIDTH+1 bits and saturated to 2^WIDTH−1.
  - If `sum >= threshold`: `spike` ← 1 and `refrac` ← REFRAC_STEPS. `state` ← 0 in mode 0, or `sum − threshold` in mode 1 (never negative).
  - Else: `state` ← `sum`, `spike` ← 0.
- On a cycle with `step`=0: `state` and `refrac` hold; `spike` ← 0.
- `reset_mode` is sampled on the step cycle. Changing it between steps is legal.
- `thr_wr`=1 loads `threshold` ← `thr_data` at that edge. When `thr_wr` and `step` coincide, the step compares against the old threshold; the new value applies from the next step.
- Threshold 0: every non-refractory step fires. In mode 1 the post-spike state then equals `sum`.
- Comparison is unsigned, inclusive (>=).

## Timing
- Reset (async assert, sync-safe deassert assumed upstream): `state`=0, `refrac`=0, `spike`=0, `spike_any`=0, `threshold`=DEFAULT_THRESHOLD. Reset takes effect immediately, mid-step included; no partial update survives.
- Latency: `state`/`spike` reflect a step one cycle after the `step` edge, i.e. visible in the cycle following `step`=1.
- `spike` is a one-cycle pulse, even with back-to-back steps. Back-to-back firing needs REFRAC_STEPS=0.
- `spike_any` is registered alongside `spike` (same cycle, not derived combinationally).
- Refractory is counted in steps, not clocks. After a fire, exactly REFRAC_STEPS subsequent steps are ignored.
- There is no handshake: `step` may be asserted every cycle.

## Structure
- Package `lif_pkg`: reset-mode constants (`LIF_RST_ZERO`=0, `LIF_RST_SUB`=1) and a saturating-add function parametrised via width argument.
- Sub-module `lif_neuron`: one channel (state, refrac, spike regs, leak/add/compare/reset datapath). It is instantiated N_NEURONS times in a generate loop. The top holds the threshold register and the `spike_any` reduction.

## Test plan
(defaults: WIDTH=8, LEAK_SHIFT=1, REFRAC_STEPS=2, threshold 127)
- Reset: drive random inputs with `rst_n` low → all `state`=0, `spike`=0, `spike_any`=0. First step with `current`=10 → `state`=10.
- Integration, mode 0: ch0 `current`=64, steps 1–7 → `state` 64,96,112,120,124,126, then fire at step 7 (sum 127) with `state`=0. Next 2 steps hold 0 with no spike; step 10 → 64.
- Saturation, mode 1: ch1 `current`=255 from state 0 → sum 255, spike, `state`=128. Other channels with `current`=0 stay 0 and do not spike.
- Threshold update: `thr_wr` with `thr_data`=50 in the same cycle as a step where ch0 sum=60 → no spike (old 127). Next step with sum ≥50 → spike.
- Idle cycles: `step`=0 for 5 cycles with nonzero `current` → `state`/`refrac` unchanged, `spike`=0. Repeat with `step` every cycle and REFRAC_STEPS=0 and `current`=255 → `spike` asserted on consecutive cycles.
- Async reset mid-run: drop `rst_n` between edges during refractory → outputs and threshold return to reset values before the next edge. The first post-reset step integrates from 0 with no refractory.
